csr_wr_arbiter: RTL and testbench

Round-robin write arbiter and owner of one shared bit-enabled control register. Up to NREQ requesters issue masked write, set, clear or toggle operations over a valid/ready handshake. At most one request commits per cycle, and only the bits selected by its mask change. The block sits between pipeline/CSR agents and any shared configuration register, and is the single write port for that register.

---
 rtl/csr_wr_arbiter.sv | 106 ++++++++++
 tb/tb_csr_wr_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_wr_arbiter.sv
// csr_wr_arbiter: round-robin arbiter and single write port for one shared,
// bit-enabled control register (masked WRITE/SET/CLR/TOG per requester).
module csr_wr_arbiter #(
    parameter int unsigned          REG_WIDTH       = 32,
    parameter int unsigned          NREQ            = 4,
    parameter logic [REG_WIDTH-1:0] REG_RESET_VALUE = '0,
    localparam int unsigned         ID_WIDTH        = $clog2(NREQ)
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [2*NREQ-1:0]         req_op,
    input  logic [REG_WIDTH*NREQ-1:0] req_mask,
    input  logic [REG_WIDTH*NREQ-1:0] req_data,
    output logic [NREQ-1:0]           req_ready,
    input  logic                      hold,
    output logic [REG_WIDTH-1:0]      q,
    output logic                      upd_valid,
    output logic [ID_WIDTH-1:0]       upd_id,
    output logic [REG_WIDTH-1:0]      upd_changed
);

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_SET   = 2'b01,
        OP_CLR   = 2'b10,
        OP_TOG   = 2'b11
    } op_e;

    logic [ID_WIDTH-1:0]  ptr_q, ptr_d;
    logic [REG_WIDTH-1:0] q_q, q_d;
    logic                 upd_valid_q;
    logic [ID_WIDTH-1:0]  upd_id_q;
    logic [REG_WIDTH-1:0] upd_changed_q;

    logic                 gnt_c;
    logic [ID_WIDTH-1:0]  gnt_id_c;
    logic [ID_WIDTH-1:0]  cand_c;
    op_e                  op_sel_c;
    logic [REG_WIDTH-1:0] mask_sel_c;
    logic [REG_WIDTH-1:0] data_sel_c;

    // Round-robin search starting at ptr; grant depends only on valid, hold, reset and ptr.
    always_comb begin
        gnt_c    = 1'b0;
        gnt_id_c = '0;
        cand_c   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand_c = ID_WIDTH'((32'(ptr_q) + k) % NREQ);
            if (!gnt_c && req_valid[cand_c]) begin
                gnt_c    = 1'b1;
                gnt_id_c = cand_c;
            end
        end
        if (!resetn || hold) begin
            gnt_c = 1'b0;
        end
        req_ready = '0;
        if (gnt_c) begin
            req_ready[gnt_id_c] = 1'b1;
        end
    end

    // Next register value and pointer for the granted requester.
    always_comb begin
        op_sel_c   = op_e'(req_op[2*gnt_id_c +: 2]);
        mask_sel_c = req_mask[REG_WIDTH*gnt_id_c +: REG_WIDTH];
        data_sel_c = req_data[REG_WIDTH*gnt_id_c +: REG_WIDTH];
        q_d        = q_q;
        ptr_d      = ptr_q;
        if (gnt_c) begin
            unique case (op_sel_c)
                OP_WRITE: q_d = (q_q & ~mask_sel_c) | (data_sel_c & mask_sel_c);
                OP_SET:   q_d = q_q | mask_sel_c;
                OP_CLR:   q_d = q_q & ~mask_sel_c;
                OP_TOG:   q_d = q_q ^ mask_sel_c;
                default:  q_d = q_q;
            endcase
            ptr_d = (32'(gnt_id_c) == NREQ - 1) ? '0 : gnt_id_c + ID_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q_q           <= REG_RESET_VALUE;
            ptr_q         <= '0;
            upd_valid_q   <= 1'b0;
            upd_id_q      <= '0;
            upd_changed_q <= '0;
        end else begin
            upd_valid_q <= gnt_c;
            if (gnt_c) begin
                q_q           <= q_d;
                ptr_q         <= ptr_d;
                upd_id_q      <= gnt_id_c;
                upd_changed_q <= q_q ^ q_d;
            end
        end
    end

    assign q           = q_q;
    assign upd_valid   = upd_valid_q;
    assign upd_id      = upd_id_q;
    assign upd_changed = upd_changed_q;

endmodule

// File: tb/tb_csr_wr_arbiter.sv
// Bench for csr_wr_arbiter: directed scenarios with literal expectations plus
// a randomized phase, all checked every cycle against a behavioural model.
module tb_csr_wr_arbiter;

    localparam int unsigned W   = 32;
    localparam int unsigned N   = 4;
    localparam int unsigned IDW = 2;
    localparam logic [W-1:0] RST_VAL = 32'h0000_00A5;

    logic           clk    = 1'b0;
    logic           resetn = 1'b0;
    logic           hold   = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [2*N-1:0] req_op    = '0;
    logic [W*N-1:0] req_mask  = '0;
    logic [W*N-1:0] req_data  = '0;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   q;
    logic           upd_valid;
    logic [IDW-1:0] upd_id;
    logic [W-1:0]   upd_changed;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    csr_wr_arbiter #(
        .REG_WIDTH       (W),
        .NREQ            (N),
        .REG_RESET_VALUE (RST_VAL)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req_valid   (req_valid),
        .req_op      (req_op),
        .req_mask    (req_mask),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .hold        (hold),
        .q           (q),
        .upd_valid   (upd_valid),
        .upd_id      (upd_id),
        .upd_changed (upd_changed)
    );

    // Behavioural model state
    logic [W-1:0] q_m   = RST_VAL;
    logic [W-1:0] chg_m = '0;
    int           ptr_m = 0;
    int           id_m  = 0;
    bit           uv_m  = 1'b0;
    int           last_gnt_m = -1;
    int           g_m;
    logic [W-1:0] nq_m;

    function automatic int pick(input logic [N-1:0] v, input int p, input bit rn, input bit h);
        int idx;
        if (!rn || h) return -1;
        for (int k = 0; k < int'(N); k++) begin
            idx = (p + k) % int'(N);
            if (v[IDW'(idx)]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] apply(input logic [W-1:0] qv, input logic [1:0] op,
                                           input logic [W-1:0] m, input logic [W-1:0] d);
        case (op)
            2'b00:   return (qv & ~m) | (d & m);
            2'b01:   return qv | m;
            2'b10:   return qv & ~m;
            default: return qv ^ m;
        endcase
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q_m = RST_VAL; ptr_m = 0; uv_m = 1'b0; id_m = 0; chg_m = '0; last_gnt_m = -1;
        end else begin
            g_m = pick(req_valid, ptr_m, resetn, hold);
            last_gnt_m = g_m;
            if (g_m >= 0) begin
                nq_m  = apply(q_m, req_op[2*g_m +: 2], req_mask[W*g_m +: W], req_data[W*g_m +: W]);
                chg_m = q_m ^ nq_m;
                q_m   = nq_m;
                id_m  = g_m;
                uv_m  = 1'b1;
                ptr_m = (g_m + 1) % int'(N);
            end else begin
                uv_m = 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        int g;
        logic [N-1:0] er;
        if (cmp_en) begin
            g  = pick(req_valid, ptr_m, resetn, hold);
            er = '0;
            if (g >= 0) er[IDW'(g)] = 1'b1;
            check("cyc_ready", 64'(req_ready), 64'(er));
            check("cyc_q", 64'(q), 64'(q_m));
            check("cyc_upd_valid", 64'(upd_valid), 64'(uv_m));
            check("cyc_upd_id", 64'(upd_id), 64'(id_m));
            check("cyc_upd_changed", 64'(upd_changed), 64'(chg_m));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input logic [1:0] op,
                           input logic [W-1:0] m, input logic [W-1:0] d);
        req_valid[IDW'(i)]  = v;
        req_op[2*i +: 2]    = op;
        req_mask[W*i +: W]  = m;
        req_data[W*i +: W]  = d;
    endtask

    task automatic clr_all();
        req_valid = '0; req_op = '0; req_mask = '0; req_data = '0;
    endtask

    task automatic do_op(input int i, input logic [1:0] op, input logic [W-1:0] m, input logic [W-1:0] d);
        set_req(i, 1'b1, op, m, d);
        step();
        req_valid[IDW'(i)] = 1'b0;
    endtask

    logic [N-1:0] rr_exp [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    int           rr_id  [6] = '{0, 1, 2, 3, 0, 1};
    bit           pend [N];

    initial begin
        resetn = 1'b0;
        repeat (2) step();
        resetn = 1'b1;
        cmp_en = 1'b1;
        check("rst_q", 64'(q), 64'(32'h0000_00A5));
        check("rst_upd_valid", 64'(upd_valid), 64'd0);

        // Move q away from reset value, then reset while req 1 is in flight
        do_op(0, 2'b00, 32'hFFFF_FFFF, 32'h0000_FFFF);
        check("pre_rst_q", 64'(q), 64'(32'h0000_FFFF));
        set_req(1, 1'b1, 2'b01, 32'hFFFF_0000, '0);
        #2 resetn = 1'b0;
        #1;
        check("async_rst_q", 64'(q), 64'(32'h0000_00A5));
        check("async_rst_ready", 64'(req_ready), 64'd0);
        check("async_rst_upd_valid", 64'(upd_valid), 64'd0);
        step();
        check("rst_hold_q", 64'(q), 64'(32'h0000_00A5));
        clr_all();
        resetn = 1'b1;

        // Round robin from reset with all four valid
        for (int i = 0; i < int'(N); i++) set_req(i, 1'b1, 2'b11, '0, '0);
        for (int c = 0; c < 6; c++) begin
            #1;
            check("rr_ready", 64'(req_ready), 64'(rr_exp[c]));
            step();
            check("rr_upd_id", 64'(upd_id), 64'(rr_id[c]));
            check("rr_upd_valid", 64'(upd_valid), 64'd1);
        end
        clr_all();

        // Single-requester operations
        do_op(0, 2'b00, 32'hFFFF_FFFF, 32'h0000_FFFF);
        check("op_init_q", 64'(q), 64'(32'h0000_FFFF));
        do_op(0, 2'b00, 32'hFF00_00FF, 32'h1234_5678);
        check("op_write_q", 64'(q), 64'(32'h1200_FF78));
        check("op_write_chg", 64'(upd_changed), 64'(32'h1200_0087));
        do_op(0, 2'b01, 32'h0001_0000, 32'h0);
        check("op_set_q", 64'(q), 64'(32'h1201_FF78));
        do_op(0, 2'b10, 32'h0000_0F00, 32'h0);
        check("op_clr_q", 64'(q), 64'(32'h1201_F078));
        do_op(0, 2'b11, 32'hFFFF_FFFF, 32'h0);
        check("op_tog_q", 64'(q), 64'(32'hEDFE_0F87));

        // Pointer wrap and skip: ptr=3 with requesters 1 and 3
        do_op(2, 2'b11, 32'h0, 32'h0);
        set_req(1, 1'b1, 2'b11, 32'h0000_0001, '0);
        set_req(3, 1'b1, 2'b01, 32'h0000_0100, '0);
        #1; check("wrap_g0", 64'(req_ready), 64'(4'b1000));
        step(); check("wrap_g1", 64'(req_ready), 64'(4'b0010));
        step(); check("wrap_g2", 64'(req_ready), 64'(4'b1000));
        step();
        clr_all();
        check("wrap_q", 64'(q), 64'(32'hEDFE_0F86));

        // Hold for three cycles with req 2 pending
        set_req(2, 1'b1, 2'b10, 32'h0000_000F, '0);
        hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("hold_ready", 64'(req_ready), 64'd0);
            step();
            check("hold_upd_valid", 64'(upd_valid), 64'd0);
            check("hold_q", 64'(q), 64'(32'hEDFE_0F86));
        end
        hold = 1'b0;
        #1;
        check("hold_release_ready", 64'(req_ready), 64'(4'b0100));
        step();
        clr_all();
        check("hold_release_q", 64'(q), 64'(32'hEDFE_0F80));
        check("hold_release_id", 64'(upd_id), 64'd2);

        // Zero-mask write still commits and advances the pointer
        do_op(0, 2'b00, 32'h0, 32'hDEAD_BEEF);
        check("zm_q", 64'(q), 64'(32'hEDFE_0F80));
        check("zm_upd_valid", 64'(upd_valid), 64'd1);
        check("zm_upd_changed", 64'(upd_changed), 64'd0);
        check("zm_upd_id", 64'(upd_id), 64'd0);
        for (int i = 0; i < 3; i++) set_req(i, 1'b1, 2'b11, '0, '0);
        #1;
        check("zm_ptr_next", 64'(req_ready), 64'(4'b0010));
        step();
        clr_all();

        // Randomized traffic obeying hold-until-ready, with legal drops
        for (int i = 0; i < int'(N); i++) pend[i] = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < int'(N); i++) begin
                if (pend[i] && last_gnt_m == i) pend[i] = 1'b0;
                if (pend[i] && ($urandom % 20) == 0) pend[i] = 1'b0;
                if (!pend[i] && ($urandom % 3) == 0) begin
                    logic [W-1:0] m;
                    case ($urandom % 4)
                        0:       m = '0;
                        1:       m = '1;
                        default: m = W'($urandom);
                    endcase
                    set_req(i, 1'b1, 2'($urandom), m, W'($urandom));
                    pend[i] = 1'b1;
                end
                req_valid[IDW'(i)] = pend[i];
            end
            hold = (($urandom % 10) == 0);
            if (c == 1500) begin
                #2 resetn = 1'b0;
                step();
                resetn = 1'b1;
                for (int i = 0; i < int'(N); i++) pend[i] = 1'b0;
                clr_all();
            end else begin
                step();
            end
        end
        hold = 1'b0;
        clr_all();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
